// File: rtl/cvd_pkg.sv
`default_nettype none
// ============================================================================
// cvd_pkg : shared coordinate type, hit FSM states and sprite/projectile sizes
// Revision: 1.0
// ============================================================================
package cvd_pkg;

   typedef logic [10:0] coord_t;

   typedef enum logic [1:0] {
      READY    = 2'd0,
      HIT      = 2'd1,
      COOLDOWN = 2'd2
   } hit_state_t;

   localparam int CVD_SPRITE_W = 64;
   localparam int CVD_SPRITE_H = 64;
   localparam int CVD_PROJ_W   = 16;
   localparam int CVD_PROJ_H   = 16;

   // A zero-frame window still needs a 1-bit counter
   function automatic int cnt_width(input int frames);
      return (frames > 0) ? $clog2(frames + 1) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/hit_generator_if.sv
`default_nettype none
// ============================================================================
// hit_generator_if : positions/frame timing in, damage and clear pulses out
// Revision: 1.0
// ============================================================================
interface hit_generator_if;
   import cvd_pkg::*;

   logic   frame_tick;
   logic   game_active;
   coord_t cat_x, cat_y;
   coord_t dog_x, dog_y;
   logic   proj_cat_vld;
   coord_t proj_cat_x, proj_cat_y;
   logic   proj_dog_vld;
   coord_t proj_dog_x, proj_dog_y;
   logic   hit_cat, hit_dog;
   logic   proj_cat_clr, proj_dog_clr;
   logic   invuln_cat, invuln_dog;

   modport master (
      output frame_tick, game_active, cat_x, cat_y, dog_x, dog_y,
             proj_cat_vld, proj_cat_x, proj_cat_y,
             proj_dog_vld, proj_dog_x, proj_dog_y,
      input  hit_cat, hit_dog, proj_cat_clr, proj_dog_clr, invuln_cat, invuln_dog
   );

   modport slave (
      input  frame_tick, game_active, cat_x, cat_y, dog_x, dog_y,
             proj_cat_vld, proj_cat_x, proj_cat_y,
             proj_dog_vld, proj_dog_x, proj_dog_y,
      output hit_cat, hit_dog, proj_cat_clr, proj_dog_clr, invuln_cat, invuln_dog
   );

endinterface
`default_nettype wire

// File: rtl/hit_channel.sv
`default_nettype none
// ============================================================================
// hit_channel : one victim's AABB test, READY/HIT/COOLDOWN FSM and cooldown
// Revision: 1.0
// ============================================================================
module hit_channel
   import cvd_pkg::*;
#(
   parameter int SPRITE_W      = CVD_SPRITE_W,
   parameter int SPRITE_H      = CVD_SPRITE_H,
   parameter int PROJ_W        = CVD_PROJ_W,
   parameter int PROJ_H        = CVD_PROJ_H,
   parameter int INVULN_FRAMES = 30
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   frame_tick_i,
   input  logic   game_active_i,
   input  coord_t vic_x_i,
   input  coord_t vic_y_i,
   input  logic   proj_vld_i,
   input  coord_t proj_x_i,
   input  coord_t proj_y_i,
   output logic   hit_o,
   output logic   clr_o,
   output logic   invuln_o
);

   localparam int         CW          = cnt_width(INVULN_FRAMES);
   localparam logic [1:0] ST_READY    = READY;
   localparam logic [1:0] ST_HIT      = HIT;
   localparam logic [1:0] ST_COOLDOWN = COOLDOWN;

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          hit_q, invuln_q;

   logic [11:0] w_px, w_py, w_sx, w_sy;
   logic        w_overlap;

   // Zero-extend before adding so boxes near the right/bottom edge never wrap
   assign w_px = {1'b0, proj_x_i};
   assign w_py = {1'b0, proj_y_i};
   assign w_sx = {1'b0, vic_x_i};
   assign w_sy = {1'b0, vic_y_i};

   assign w_overlap = (w_px < w_sx + 12'(SPRITE_W)) && (w_px + 12'(PROJ_W) > w_sx) &&
                      (w_py < w_sy + 12'(SPRITE_H)) && (w_py + 12'(PROJ_H) > w_sy);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (!game_active_i) begin
         state_d = ST_READY;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ST_READY: begin
               if (frame_tick_i && proj_vld_i && w_overlap)
                  state_d = ST_HIT;
            end
            ST_HIT: begin
               cnt_d   = CW'(INVULN_FRAMES);
               state_d = (INVULN_FRAMES == 0) ? ST_READY : ST_COOLDOWN;
            end
            ST_COOLDOWN: begin
               // The expiring tick is consumed here, so it can never also hit
               if (frame_tick_i) begin
                  cnt_d = cnt_q - CW'(1);
                  if (cnt_q <= CW'(1))
                     state_d = ST_READY;
               end
            end
            default: begin
               state_d = ST_READY;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_READY;
         cnt_q    <= '0;
         hit_q    <= 1'b0;
         invuln_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hit_q    <= (state_d == ST_HIT);
         invuln_q <= (state_d == ST_COOLDOWN);
      end
   end

   assign hit_o    = hit_q;
   assign clr_o    = hit_q;
   assign invuln_o = invuln_q;

endmodule
`default_nettype wire

// File: rtl/hit_generator.sv
`default_nettype none
// ============================================================================
// hit_generator : per-frame projectile-vs-character hit detection, two channels
// Revision: 1.0
// ============================================================================
module hit_generator
   import cvd_pkg::*;
#(
   parameter int SPRITE_W      = CVD_SPRITE_W,
   parameter int SPRITE_H      = CVD_SPRITE_H,
   parameter int PROJ_W        = CVD_PROJ_W,
   parameter int PROJ_H        = CVD_PROJ_H,
   parameter int INVULN_FRAMES = 30
) (
   input  logic          clk,
   input  logic          rst_n,
   hit_generator_if.slave bus
);

   // Cat is struck by the dog's projectile
   hit_channel #(
      .SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H),
      .PROJ_W(PROJ_W), .PROJ_H(PROJ_H), .INVULN_FRAMES(INVULN_FRAMES)
   ) u_cat_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .frame_tick_i (bus.frame_tick),
      .game_active_i(bus.game_active),
      .vic_x_i      (bus.cat_x),
      .vic_y_i      (bus.cat_y),
      .proj_vld_i   (bus.proj_dog_vld),
      .proj_x_i     (bus.proj_dog_x),
      .proj_y_i     (bus.proj_dog_y),
      .hit_o        (bus.hit_cat),
      .clr_o        (bus.proj_dog_clr),
      .invuln_o     (bus.invuln_cat)
   );

   hit_channel #(
      .SPRITE_W(SPRITE_W), .SPRITE_H(SPRITE_H),
      .PROJ_W(PROJ_W), .PROJ_H(PROJ_H), .INVULN_FRAMES(INVULN_FRAMES)
   ) u_dog_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .frame_tick_i (bus.frame_tick),
      .game_active_i(bus.game_active),
      .vic_x_i      (bus.dog_x),
      .vic_y_i      (bus.dog_y),
      .proj_vld_i   (bus.proj_cat_vld),
      .proj_x_i     (bus.proj_cat_x),
      .proj_y_i     (bus.proj_cat_y),
      .hit_o        (bus.hit_dog),
      .clr_o        (bus.proj_cat_clr),
      .invuln_o     (bus.invuln_dog)
   );

endmodule
`default_nettype wire

// File: tb/tb_hit_generator.sv
`default_nettype none
// ============================================================================
// tb_hit_generator : scoreboarded directed + random bench for hit_generator
// Revision: 1.0
// ============================================================================
module tb_hit_generator;
   import cvd_pkg::*;

   localparam int INV = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hit_generator_if bus ();

   hit_generator #(.INVULN_FRAMES(INV)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   typedef struct {
      logic  hc, hd, cc, cd, ic, id;
      string tag;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;

   // Reference: per victim (0 = cat, 1 = dog) the number of ticks still to ignore
   int ign[2];
   bit hn[2];

   function automatic bit ovl(input int px, input int py, input int sx, input int sy);
      return (px < sx + CVD_SPRITE_W) && (px + CVD_PROJ_W > sx) &&
             (py < sy + CVD_SPRITE_H) && (py + CVD_PROJ_H > sy);
   endfunction

   task automatic chk(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   // Called at a falling edge with inputs already driven; predicts the next edge
   task automatic step(input string tag);
      exp_t e;
      bit   hnext[2];
      bit   vld[2];
      bit   ov[2];
      vld[0] = bus.proj_dog_vld;
      vld[1] = bus.proj_cat_vld;
      ov[0]  = ovl(int'(bus.proj_dog_x), int'(bus.proj_dog_y), int'(bus.cat_x), int'(bus.cat_y));
      ov[1]  = ovl(int'(bus.proj_cat_x), int'(bus.proj_cat_y), int'(bus.dog_x), int'(bus.dog_y));
      for (int v = 0; v < 2; v++) begin
         hnext[v] = 1'b0;
         if (!rst_n || !bus.game_active) begin
            ign[v] = 0;
         end else if (!hn[v] && bus.frame_tick) begin
            if (ign[v] > 0) ign[v]--;
            else if (vld[v] && ov[v]) begin
               hnext[v] = 1'b1;
               ign[v]   = INV;
            end
         end
      end
      e.hc  = hnext[0];
      e.cd  = hnext[0];
      e.hd  = hnext[1];
      e.cc  = hnext[1];
      e.ic  = (ign[0] > 0) && !hnext[0];
      e.id  = (ign[1] > 0) && !hnext[1];
      e.tag = tag;
      hn    = hnext;
      q.push_back(e);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic cyc(input logic tick, input string tag);
      bus.frame_tick = tick;
      step(tag);
      bus.frame_tick = 1'b0;
   endtask

   task automatic drain();
      bus.proj_cat_vld = 1'b0;
      bus.proj_dog_vld = 1'b0;
      for (int i = 0; i < INV + 1; i++) begin
         cyc(1'b1, "drain");
         cyc(1'b0, "drain");
      end
   endtask

   task automatic async_reset_check(input string tag);
      rst_n = 1'b0;
      #1;
      chk({tag, "_hit_cat"}, bus.hit_cat, 1'b0);
      chk({tag, "_hit_dog"}, bus.hit_dog, 1'b0);
      chk({tag, "_clr_cat"}, bus.proj_cat_clr, 1'b0);
      chk({tag, "_clr_dog"}, bus.proj_dog_clr, 1'b0);
      chk({tag, "_inv_cat"}, bus.invuln_cat, 1'b0);
      chk({tag, "_inv_dog"}, bus.invuln_dog, 1'b0);
      cyc(1'b0, {tag, "_held"});
      rst_n = 1'b1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk({e.tag, "_hit_cat"}, bus.hit_cat, e.hc);
            chk({e.tag, "_hit_dog"}, bus.hit_dog, e.hd);
            chk({e.tag, "_clr_cat"}, bus.proj_cat_clr, e.cc);
            chk({e.tag, "_clr_dog"}, bus.proj_dog_clr, e.cd);
            chk({e.tag, "_inv_cat"}, bus.invuln_cat, e.ic);
            chk({e.tag, "_inv_dog"}, bus.invuln_dog, e.id);
         end
      end
   end

   initial begin : stimulus
      int tx, ty;
      ign = '{0, 0};
      hn  = '{0, 0};
      bus.frame_tick   = 1'b0;
      bus.game_active  = 1'b1;
      bus.cat_x = 11'd100; bus.cat_y = 11'd100;
      bus.dog_x = 11'd500; bus.dog_y = 11'd600;
      bus.proj_cat_vld = 1'b0; bus.proj_cat_x = 11'd0; bus.proj_cat_y = 11'd0;
      bus.proj_dog_vld = 1'b0; bus.proj_dog_x = 11'd0; bus.proj_dog_y = 11'd0;
      @(negedge clk);
      cyc(1'b1, "reset");
      cyc(1'b0, "reset");
      rst_n = 1'b1;
      cyc(1'b0, "idle");

      // Direct hit, then cooldown with overlap held every frame
      bus.proj_cat_vld = 1'b1; bus.proj_cat_x = 11'd520; bus.proj_cat_y = 11'd620;
      for (int t = 0; t < 6; t++) begin
         cyc(1'b1, $sformatf("cool_t%0d", t + 1));
         for (int k = 0; k < 3; k++) cyc(1'b0, $sformatf("cool_gap%0d", t + 1));
      end
      drain();

      // Edge touch then one pixel inside
      bus.proj_cat_vld = 1'b1; bus.proj_cat_x = 11'd564; bus.proj_cat_y = 11'd600;
      cyc(1'b1, "edge64");
      cyc(1'b0, "edge64");
      bus.proj_cat_x = 11'd563;
      cyc(1'b1, "edge63");
      cyc(1'b0, "edge63");
      drain();

      // Simultaneous hits
      bus.proj_cat_vld = 1'b1; bus.proj_cat_x = 11'd510; bus.proj_cat_y = 11'd610;
      bus.proj_dog_vld = 1'b1; bus.proj_dog_x = 11'd110; bus.proj_dog_y = 11'd110;
      cyc(1'b1, "simul");
      cyc(1'b0, "simul");
      drain();

      // Game inactive, then mid-cooldown deassert
      bus.proj_cat_vld = 1'b1; bus.proj_dog_vld = 1'b1;
      bus.game_active = 1'b0;
      cyc(1'b1, "inactive");
      cyc(1'b0, "inactive");
      bus.game_active = 1'b1;
      cyc(1'b1, "reenable");
      cyc(1'b0, "reenable");
      cyc(1'b0, "cooling");
      bus.game_active = 1'b0;
      cyc(1'b0, "deassert");
      cyc(1'b0, "deassert");
      bus.game_active = 1'b1;
      cyc(1'b1, "rehit");
      cyc(1'b0, "rehit");

      // Asynchronous reset during the HIT cycle and mid-cooldown
      drain();
      bus.proj_cat_vld = 1'b1; bus.proj_dog_vld = 1'b1;
      bus.frame_tick = 1'b1;
      step("pre_rst");
      bus.frame_tick = 1'b0;
      async_reset_check("rst_in_hit");
      cyc(1'b1, "post_rst");
      cyc(1'b0, "post_rst");
      cyc(1'b1, "cool_rst");
      async_reset_check("rst_in_cool");
      cyc(1'b1, "post_rst2");
      cyc(1'b0, "post_rst2");

      // Randomised play, including targets near the right/bottom edge
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 49) == 0) begin
            bus.cat_x = coord_t'($urandom_range(0, 2047));
            bus.cat_y = coord_t'($urandom_range(0, 2047));
            bus.dog_x = coord_t'($urandom_range(0, 2047));
            bus.dog_y = coord_t'($urandom_range(0, 2047));
         end
         tx = int'(bus.dog_x); ty = int'(bus.dog_y);
         bus.proj_cat_x   = coord_t'(tx + int'($urandom_range(0, 110)) - 30);
         bus.proj_cat_y   = coord_t'(ty + int'($urandom_range(0, 110)) - 30);
         tx = int'(bus.cat_x); ty = int'(bus.cat_y);
         bus.proj_dog_x   = coord_t'(tx + int'($urandom_range(0, 110)) - 30);
         bus.proj_dog_y   = coord_t'(ty + int'($urandom_range(0, 110)) - 30);
         bus.proj_cat_vld = ($urandom_range(0, 3) != 0);
         bus.proj_dog_vld = ($urandom_range(0, 3) != 0);
         bus.game_active  = ($urandom_range(0, 29) != 0);
         cyc(($urandom_range(0, 2) == 0), "rand");
      end

      cyc(1'b0, "final");
      chk("queue_empty", (q.size() == 0), 1'b1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
